// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//   Turns raw PS/2 set-2 scan-code bytes into ASCII characters and queues them
//   for a downstream consumer. Break (F0) and extended (E0) prefixes are
//   stripped, left/right Shift (12/59) is tracked, and lookup letters are
//   folded to lower case when Shift is not held. The scan-code-to-ASCII table
//   lives outside this block: key_code_o drives it, and ascii_i returns the
//   result combinationally in the same cycle.
//
// Ports
//   clk_i         system clock, all state on the rising edge
//   reset_n_i     asynchronous active-low reset
//   scan_data_i   scan-code byte from the PS/2 receiver
//   scan_valid_i  one-cycle strobe qualifying scan_data_i
//   key_code_o    registered make code presented to the lookup
//   ascii_i       lookup result for key_code_o
//   out_data_o    FIFO head character
//   out_valid_o   FIFO not empty
//   out_ready_i   consumer accepts the head when out_valid_o=1
//   overflow_o    sticky flag: a character or scan byte was dropped
//   ovf_clr_i     synchronous clear of overflow_o (a new drop wins)
//
// Build option
//   PS2_DROP_UNMAPPED_EN : when defined, lookup results equal to 8'h2A (the
//   table's default for unmapped keys) are discarded instead of queued.
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a new byte; Shift make codes handled here
// BRK     | F0 seen; next byte is the released key
// EXT     | E0 seen; extended make code or F0 expected next
// EXT_BRK | E0 F0 seen; next byte is the released extended key
// LOOKUP  | key_code_o valid on the lookup; sample ascii_i and push

module ps2_key_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] scan_data_i,
    input  logic       scan_valid_i,
    output logic [7:0] key_code_o,
    input  logic [7:0] ascii_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       overflow_o,
    input  logic       ovf_clr_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BRK     = 3'd1,
        EXT     = 3'd2,
        EXT_BRK = 3'd3,
        LOOKUP  = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        shift_q, shift_d;
    logic        push_req;
    logic [7:0]  push_val;
    logic        lookup_drop;

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic        overflow_q;
    logic        full, empty, pop, push_ok, push_drop;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            key_code_q <= 8'h00;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_code_q <= key_code_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        push_val    = ascii_i;
        lookup_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_valid_i) begin
                    case (scan_data_i)
                        8'hF0: state_d = BRK;
                        8'hE0: state_d = EXT;
                        8'h12, 8'h59: shift_d = 1'b1;
                        // Keyboard status/response bytes, not keys.
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: ;
                        default: begin
                            key_code_d = scan_data_i;
                            state_d    = LOOKUP;
                        end
                    endcase
                end
            end
            BRK: begin
                if (scan_valid_i) begin
                    state_d = IDLE;
                    if (scan_data_i == 8'h12 || scan_data_i == 8'h59) begin
                        shift_d = 1'b0;
                    end
                end
            end
            EXT: begin
                if (scan_valid_i) begin
                    case (scan_data_i)
                        8'hF0:   state_d = EXT_BRK;
                        8'hE0:   state_d = EXT;
                        default: state_d = IDLE;
                    endcase
                end
            end
            EXT_BRK: begin
                if (scan_valid_i) begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                state_d     = IDLE;
                // The FSM cannot accept a byte while it is sampling the lookup.
                lookup_drop = scan_valid_i;
                if (ascii_i >= 8'h41 && ascii_i <= 8'h5A && !shift_q) begin
                    push_val = ascii_i + 8'h20;
                end
`ifdef PS2_DROP_UNMAPPED_EN
                push_req = (ascii_i != 8'h2A);
`else
                push_req = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------------- FIFO
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = !empty && out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_val;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (push_drop || lookup_drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign key_code_o  = key_code_q;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_valid_o = !empty;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic [7:0] key_code;
    logic [7:0] ascii;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_key_sequencer #(.DEPTH(8), .AW(3)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .scan_data_i  (scan_data),
        .scan_valid_i (scan_valid),
        .key_code_o   (key_code),
        .ascii_i      (ascii),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .overflow_o   (overflow),
        .ovf_clr_i    (ovf_clr)
    );

    // Small stand-in for the external scan-code table.
    always_comb begin
        case (key_code)
            8'h1C:   ascii = 8'h41;  // A
            8'h16:   ascii = 8'h31;  // 1
            8'h29:   ascii = 8'h20;  // space
            8'h45:   ascii = 8'h30;  // 0
            default: ascii = 8'h2A;  // unmapped
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each accepted head is compared with the oldest
    // expected character.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    // Strobe one byte, then allow one extra cycle for a possible LOOKUP.
    task automatic send(input logic [7:0] b);
        scan_data  = b;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check({name, "_drain_done"}, {31'd0, out_valid}, 32'd0);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        scan_data  = 8'h00;
        scan_valid = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        check("rst_key_code",  key_code,  8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_overflow",  overflow,  1'b0);

        // Basic latency: strobe in N, key_code at N+1, out_valid at N+2.
        scan_data  = 8'h1C;
        scan_valid = 1'b1;
        exp_q.push_back(8'h61);
        @(posedge clk); #1;
        scan_valid = 1'b0;
        check("lat_key_code",   key_code,  8'h1C);
        check("lat_valid_n1",   out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_valid_n2",   out_valid, 1'b1);
        check("lat_data_n2",    out_data,  8'h61);
        drain("basic");

        // Shift tracking and break codes.
        send(8'h12);
        send(8'h1C); exp_q.push_back(8'h41);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12);
        send(8'h1C); exp_q.push_back(8'h61);
        check("shift_head",     out_data,    8'h41);
        check("shift_released", dut.shift_q, 1'b0);
        drain("shift");

        // Extended sequences produce nothing; right Shift (59) also works.
        send(8'hE0); send(8'h75);
        check("ext_no_char",  out_valid, 1'b0);
        check("ext_key_hold", key_code,  8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("extbrk_no_char", out_valid, 1'b0);
        send(8'h16); exp_q.push_back(8'h31);
        check("ext_then_1", out_data, 8'h31);
        send(8'h59);
        send(8'h45); exp_q.push_back(8'h30);
        send(8'hAA);
        check("status_ignored", key_code, 8'h45);
        send(8'hF0); send(8'h59);
        drain("ext");

        // Fill past full: ninth character dropped and flagged.
        for (int i = 0; i < 9; i++) begin
            send(8'h29);
            if (i < 8) exp_q.push_back(8'h20);
            if (i == 7) check("full_no_ovf", overflow, 1'b0);
        end
        check("full_ovf_set", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        drain("full");

        // Full FIFO, push and pop in the same cycle: both accepted.
        for (int i = 0; i < 8; i++) begin
            send(8'h29);
            exp_q.push_back(8'h20);
        end
        scan_data  = 8'h1C;
        scan_valid = 1'b1;
        exp_q.push_back(8'h61);
        @(posedge clk); #1;
        scan_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        check("fullpp_count", dut.count_q, 4'd8);
        check("fullpp_ovf",   overflow,    1'b0);
        drain("fullpp");

        // Byte during LOOKUP is dropped; the drop outranks ovf_clr.
        scan_data  = 8'h1C;
        scan_valid = 1'b1;
        exp_q.push_back(8'h61);
        @(posedge clk); #1;
        scan_data  = 8'h16;
        ovf_clr    = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        ovf_clr    = 1'b0;
        check("lookup_drop_ovf", overflow, 1'b1);
        @(posedge clk); #1;
        drain("lookup_drop");
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;

        // Reset after F0 discards prefix and queued characters.
        send(8'h29);
        send(8'hF0);
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst2_valid", out_valid, 1'b0);
        send(8'h1C); exp_q.push_back(8'h61);
        check("rst2_char", out_data, 8'h61);
        drain("rst2");

        // Unmapped lookup result.
        send(8'h7C);
`ifdef PS2_DROP_UNMAPPED_EN
        check("unmapped_valid", out_valid, 1'b0);
`else
        exp_q.push_back(8'h2A);
        check("unmapped_valid", out_valid, 1'b1);
        check("unmapped_data",  out_data,  8'h2A);
`endif
        check("unmapped_ovf", overflow, 1'b0);
        drain("unmapped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Sequences the combinational scan-code-to-ASCII lookup for the PS/2 keyboard path.
- Consumes raw set-2 scan-code bytes from the PS/2 receiver and strips break (F0) and extended (E0) prefixes.
- Tracks Shift and folds lookup letters to lower case when Shift is not held.
- Buffers resulting ASCII characters in a small FIFO for the downstream consumer (text/VGA writer).

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- scan_data  in  8  scan-code byte from PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_data valid this cycle.
- key_code  out  8  registered code driven to the lookup.
- ascii_code  in  8  lookup result for key_code (combinational, same cycle).
- out_data  out  8  FIFO head character.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head when out_valid=1.
- overflow  out  1  sticky; a character or byte was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values: state=IDLE, key_code=8'h00, shift_held=0, FIFO empty, out_valid=0, out_data=8'h00, overflow=0. Reset mid-sequence discards the partial prefix and all FIFO contents.
- FSM states: IDLE, BRK, EXT, EXT_BRK, LOOKUP. Bytes are only acted on when scan_valid=1.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - 12 or 59 -> shift_held=1, stay IDLE.
  - AA, FA, EE, FE, 00, FF, E1 -> ignored, stay IDLE.
  - Any other byte -> key_code<=byte, go to LOOKUP.
- BRK: any byte -> IDLE. If the byte is 12 or 59, clear shift_held. No character is produced.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Any other byte -> IDLE, discarded (extended keys produce no character).
- EXT_BRK: any byte -> IDLE, discarded.
- LOOKUP (exactly one cycle):
  - Sample ascii_code.
  - If the value is in 41..5A and shift_held=0, push ascii_code+8'h20; otherwise push ascii_code unchanged.
  - Go to IDLE.
  - If scan_valid=1 during LOOKUP, that byte is dropped and overflow is set.
- Latency: make-code strobe in cycle N -> key_code updates at N+1 -> push at end of N+1 -> out_valid=1 and out_data valid at N+2 if the FIFO was empty. No fall-through.
- Typematic repeats (the same make code without a break) each produce a character.
- FIFO:
  - Pop when out_valid & out_ready.
  - out_data is always the head entry and is registered/RAM-read without a bubble.
  - Push when full with no pop the same cycle: character dropped, overflow<=1.
  - Push and pop in the same cycle when full: both accepted, count unchanged.
  - Push and pop in the same cycle when empty: push accepted, pop ignored (out_valid was 0).
  - Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- overflow: set has priority over ovf_clr in the same cycle.

Optional Feature:
- Macro: PS2_DROP_UNMAPPED_EN.
- Defined: in LOOKUP, an ascii_code of 8'h2A (the lookup's unmapped default) is not pushed; the FSM returns to IDLE, overflow is unaffected, and no character appears.
- Undefined: 8'h2A is pushed like any other character.

Test Plan:
- Reset, then strobe 1C -> key_code=1C one cycle later; out_valid rises two cycles after the strobe with out_data=61 ('a'); out_ready=1 pops it and out_valid returns to 0.
- Strobe 12, 1C, F0, 1C, F0, 12, 1C -> FIFO holds 41 then 61; no character for the break codes; shift_held=0 at the end.
- Strobe E0, 75, E0, F0, 75, then 16 -> only 31 ('1') is pushed; state returns to IDLE after each extended sequence.
- With out_ready=0, strobe 29 nine times (DEPTH=8) -> eight 20 entries; overflow=1 after the ninth; ovf_clr -> overflow=0; drain yields exactly eight 20s.
- Fill to full, then present a push in the same cycle as out_ready=1 -> count stays 8 and overflow stays 0. Separately, assert reset_n=0 for one cycle after F0 -> next 1C yields 61.
- Strobe 7C (unmapped) -> 2A is pushed with the macro undefined; with PS2_DROP_UNMAPPED_EN defined, nothing is pushed and out_valid stays 0.
